// File: rtl/bsg_cache_nb_way_reservation_chooser.sv
`timescale 1ns/1ps
// Registered miss-fill way chooser with an internal reservation table: picks a victim way that is
// not locked, not reserved by an outstanding miss in the same set, and not being filled by any channel.
module bsg_cache_nb_way_reservation_chooser #(
  parameter int unsigned sets_p     = 64,
  parameter int unsigned ways_p     = 4,
  parameter int unsigned num_chan_p = 2,
  parameter int unsigned num_resv_p = 4,
  localparam int unsigned lg_sets_lp = (sets_p == 1) ? 1 : $clog2(sets_p),
  localparam int unsigned lg_ways_lp = (ways_p == 1) ? 1 : $clog2(ways_p),
  localparam int unsigned lg_resv_lp = (num_resv_p == 1) ? 1 : $clog2(num_resv_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             v_i,
  output logic                             ready_o,
  input  logic [lg_sets_lp-1:0]            index_i,
  input  logic [ways_p-1:0]                valid_i,
  input  logic [ways_p-1:0]                lock_i,
  input  logic [ways_p-2:0]                lru_bits_i,
  input  logic [num_chan_p-1:0]            fill_v_i,
  input  logic [num_chan_p*lg_sets_lp-1:0] fill_index_i,
  input  logic [num_chan_p*lg_ways_lp-1:0] fill_way_i,
  output logic                             v_o,
  input  logic                             yumi_i,
  output logic [lg_ways_lp-1:0]            way_o,
  output logic [lg_resv_lp-1:0]            id_o,
  output logic                             no_way_o,
  input  logic                             release_v_i,
  input  logic [lg_resv_lp-1:0]            release_id_i,
  output logic [lg_resv_lp:0]              resv_count_o
);

  localparam int unsigned             count_w_lp  = lg_resv_lp + 1;
  localparam logic [count_w_lp-1:0]   resv_max_lp = count_w_lp'(num_resv_p);

  logic [num_resv_p-1:0] entry_v_q, entry_v_d;
  logic [lg_sets_lp-1:0] entry_set_q [num_resv_p];
  logic [lg_sets_lp-1:0] entry_set_d [num_resv_p];
  logic [lg_ways_lp-1:0] entry_way_q [num_resv_p];
  logic [lg_ways_lp-1:0] entry_way_d [num_resv_p];
  logic [count_w_lp-1:0] resv_count_q, resv_count_d;

  logic                  v_q, v_d;
  logic [lg_ways_lp-1:0] way_q, way_d;
  logic [lg_resv_lp-1:0] id_q, id_d;
  logic                  no_way_q, no_way_d;

  logic [ways_p-1:0]     disabled, avail;
  logic                  all_disabled;
  logic [lg_ways_lp-1:0] choice_way;
  logic                  avail_found;
  int unsigned           node, lo, size;
  logic                  left_all, right_all, bit_v;
  logic [lg_resv_lp-1:0] free_id;
  logic                  free_found;
  logic                  full, accept, alloc, rel_valid;

  // Registered table state only: a same-cycle release still disables its way.
  always_comb begin
    for (int unsigned w = 0; w < ways_p; w++) begin
      disabled[w] = lock_i[w];
      for (int unsigned e = 0; e < num_resv_p; e++) begin
        if (entry_v_q[e] && ((sets_p == 1) || (entry_set_q[e] == index_i))
            && (entry_way_q[e] == lg_ways_lp'(w)))
          disabled[w] = 1'b1;
      end
      for (int unsigned c = 0; c < num_chan_p; c++) begin
        if (fill_v_i[c] && ((sets_p == 1) || (fill_index_i[c*lg_sets_lp +: lg_sets_lp] == index_i))
            && (fill_way_i[c*lg_ways_lp +: lg_ways_lp] == lg_ways_lp'(w)))
          disabled[w] = 1'b1;
      end
    end
    all_disabled = &disabled;
    avail        = ~valid_i & ~disabled;
  end

  // Invalid enabled way first; otherwise tree LRU, each node forced away from a fully disabled half.
  always_comb begin
    choice_way  = '0;
    avail_found = 1'b0;
    node        = 0;
    lo          = 0;
    size        = 0;
    left_all    = 1'b0;
    right_all   = 1'b0;
    bit_v       = 1'b0;
    if (|avail) begin
      for (int unsigned w = 0; w < ways_p; w++) begin
        if (!avail_found && avail[w]) begin
          choice_way  = lg_ways_lp'(w);
          avail_found = 1'b1;
        end
      end
    end else begin
      for (int unsigned l = 0; l < lg_ways_lp; l++) begin
        size      = ways_p >> (l + 1);
        left_all  = 1'b1;
        right_all = 1'b1;
        for (int unsigned k = 0; k < ways_p; k++) begin
          if (k >= lo && k < lo + size)
            left_all = left_all & disabled[k];
          else if (k >= lo + size && k < lo + 2 * size)
            right_all = right_all & disabled[k];
        end
        bit_v = lru_bits_i[node];
        if (left_all)
          bit_v = 1'b1;
        else if (right_all)
          bit_v = 1'b0;
        choice_way = (choice_way << 1) | lg_ways_lp'(bit_v);
        node       = 2 * node + 1 + 32'(bit_v);
        lo         = lo + (bit_v ? size : 0);
      end
    end
  end

  always_comb begin
    free_id    = '0;
    free_found = 1'b0;
    rel_valid  = 1'b0;
    for (int unsigned e = 0; e < num_resv_p; e++) begin
      if (!free_found && !entry_v_q[e]) begin
        free_id    = lg_resv_lp'(e);
        free_found = 1'b1;
      end
      if (release_v_i && (release_id_i == lg_resv_lp'(e)) && entry_v_q[e])
        rel_valid = 1'b1;
    end
    full    = (resv_count_q == resv_max_lp);
    ready_o = (~v_q | yumi_i) & ~full;
    accept  = v_i & ready_o;
    alloc   = accept & ~all_disabled & free_found;
  end

  always_comb begin
    entry_v_d = entry_v_q;
    for (int unsigned e = 0; e < num_resv_p; e++) begin
      entry_set_d[e] = entry_set_q[e];
      entry_way_d[e] = entry_way_q[e];
      if (release_v_i && (release_id_i == lg_resv_lp'(e)))
        entry_v_d[e] = 1'b0;
      if (alloc && (free_id == lg_resv_lp'(e))) begin
        entry_v_d[e]   = 1'b1;
        entry_set_d[e] = index_i;
        entry_way_d[e] = choice_way;
      end
    end
    case ({alloc, rel_valid})
      2'b10:   resv_count_d = resv_count_q + count_w_lp'(1);
      2'b01:   resv_count_d = resv_count_q - count_w_lp'(1);
      default: resv_count_d = resv_count_q;
    endcase
  end

  always_comb begin
    v_d      = v_q;
    way_d    = way_q;
    id_d     = id_q;
    no_way_d = no_way_q;
    if (accept) begin
      v_d      = 1'b1;
      no_way_d = all_disabled;
      way_d    = all_disabled ? '0 : choice_way;
      id_d     = alloc ? free_id : '0;
    end else if (yumi_i) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      entry_v_q    <= '0;
      resv_count_q <= '0;
      v_q          <= 1'b0;
      way_q        <= '0;
      id_q         <= '0;
      no_way_q     <= 1'b0;
      for (int unsigned e = 0; e < num_resv_p; e++) begin
        entry_set_q[e] <= '0;
        entry_way_q[e] <= '0;
      end
    end else begin
      entry_v_q    <= entry_v_d;
      resv_count_q <= resv_count_d;
      v_q          <= v_d;
      way_q        <= way_d;
      id_q         <= id_d;
      no_way_q     <= no_way_d;
      for (int unsigned e = 0; e < num_resv_p; e++) begin
        entry_set_q[e] <= entry_set_d[e];
        entry_way_q[e] <= entry_way_d[e];
      end
    end
  end

  assign v_o          = v_q;
  assign way_o        = way_q;
  assign id_o         = id_q;
  assign no_way_o     = no_way_q;
  assign resv_count_o = resv_count_q;

`ifndef SYNTHESIS
  a_yumi_without_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> v_q) else $error("yumi_i asserted without v_o");
  a_release_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    release_v_i |-> (32'(release_id_i) < num_resv_p)) else $error("release_id_i out of range");
  a_release_invalid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (release_v_i && (32'(release_id_i) < num_resv_p)) |-> rel_valid)
    else $error("release of an invalid reservation");
`endif

endmodule

// File: tb/tb_bsg_cache_nb_way_reservation_chooser.sv
`timescale 1ns/1ps
// Scoreboard bench: expected results are queued at accept and compared when v_o is consumed.
module tb_bsg_cache_nb_way_reservation_chooser;

  localparam int unsigned SETS = 16;
  localparam int unsigned WAYS = 4;
  localparam int unsigned CHAN = 2;
  localparam int unsigned RESV = 4;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       v_i = 1'b0;
  logic       ready_o;
  logic [3:0] index_i = '0;
  logic [3:0] valid_i = '0;
  logic [3:0] lock_i = '0;
  logic [2:0] lru_bits_i = '0;
  logic [1:0] fill_v_i = '0;
  logic [7:0] fill_index_i = '0;
  logic [3:0] fill_way_i = '0;
  logic       v_o;
  logic       yumi_i = 1'b0;
  logic [1:0] way_o;
  logic [1:0] id_o;
  logic       no_way_o;
  logic       release_v_i = 1'b0;
  logic [1:0] release_id_i = '0;
  logic [2:0] resv_count_o;

  typedef struct {
    logic [1:0] way;
    logic [1:0] id;
    logic       no_way;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic hold = 1'b0;

  bsg_cache_nb_way_reservation_chooser #(
    .sets_p     (SETS),
    .ways_p     (WAYS),
    .num_chan_p (CHAN),
    .num_resv_p (RESV)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .index_i      (index_i),
    .valid_i      (valid_i),
    .lock_i       (lock_i),
    .lru_bits_i   (lru_bits_i),
    .fill_v_i     (fill_v_i),
    .fill_index_i (fill_index_i),
    .fill_way_i   (fill_way_i),
    .v_o          (v_o),
    .yumi_i       (yumi_i),
    .way_o        (way_o),
    .id_o         (id_o),
    .no_way_o     (no_way_o),
    .release_v_i  (release_v_i),
    .release_id_i (release_id_i),
    .resv_count_o (resv_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Consumer: each presented result is compared against the queue head and consumed.
  always @(negedge clk_i) begin
    exp_t e;
    if (v_o && !hold) begin
      check_eq("result_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("way_o", 32'(way_o), 32'(e.way));
        check_eq("id_o", 32'(id_o), 32'(e.id));
        check_eq("no_way_o", 32'(no_way_o), 32'(e.no_way));
      end
      yumi_i = 1'b1;
    end else begin
      yumi_i = 1'b0;
    end
  end

  task automatic req(input logic [3:0] idx, input logic [3:0] valid, input logic [3:0] lock,
                     input logic [2:0] lru, input logic [1:0] fv, input logic [7:0] fidx,
                     input logic [3:0] fway, input logic rel_v, input logic [1:0] rel_id,
                     input logic exp_rdy, input logic [1:0] ew, input logic [1:0] ei,
                     input logic enw);
    exp_t e;
    @(negedge clk_i);
    #2;
    index_i      = idx;
    valid_i      = valid;
    lock_i       = lock;
    lru_bits_i   = lru;
    fill_v_i     = fv;
    fill_index_i = fidx;
    fill_way_i   = fway;
    release_v_i  = rel_v;
    release_id_i = rel_id;
    v_i          = 1'b1;
    check_eq("ready_o", 32'(ready_o), 32'(exp_rdy));
    if (exp_rdy) begin
      e.way    = ew;
      e.id     = ei;
      e.no_way = enw;
      exp_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
    v_i         = 1'b0;
    release_v_i = 1'b0;
    fill_v_i    = '0;
  endtask

  task automatic rel(input logic [1:0] id);
    @(negedge clk_i);
    #2;
    release_v_i  = 1'b1;
    release_id_i = id;
    @(posedge clk_i);
    #1;
    release_v_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_v_o", 32'(v_o), 0);
    check_eq("rst_way_o", 32'(way_o), 0);
    check_eq("rst_id_o", 32'(id_o), 0);
    check_eq("rst_no_way_o", 32'(no_way_o), 0);
    check_eq("rst_count", 32'(resv_count_o), 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // Lowest invalid way of set 3 (way 2), first entry.
    req(4'd3, 4'b1011, 4'b0000, 3'b000, 2'b00, 8'h00, 4'h0, 1'b0, 2'd0, 1'b1, 2'd2, 2'd0, 1'b0);
    check_eq("t1_v_o", 32'(v_o), 1);
    check_eq("t1_count", 32'(resv_count_o), 1);

    // All valid, LRU points at way 0, then steers around reserved ways; back-to-back.
    req(4'd3, 4'b1111, 4'b0000, 3'b000, 2'b00, 8'h00, 4'h0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0);
    req(4'd3, 4'b1111, 4'b0000, 3'b000, 2'b00, 8'h00, 4'h0, 1'b0, 2'd0, 1'b1, 2'd1, 2'd2, 1'b0);
    check_eq("t2_count", 32'(resv_count_o), 3);
    rel(2'd1);
    rel(2'd2);
    check_eq("t2_count_released", 32'(resv_count_o), 1);

    // Fill ch0 on way 1, lock way 3, way 2 reserved; ch1 inactive on way 0.
    req(4'd3, 4'b1111, 4'b1000, 3'b111, 2'b01, {4'd3, 4'd3}, {2'd0, 2'd1}, 1'b0, 2'd0,
        1'b1, 2'd0, 2'd1, 1'b0);
    check_eq("t3_count", 32'(resv_count_o), 2);
    // Way 0 now reserved too: nothing left.
    req(4'd3, 4'b1111, 4'b1000, 3'b111, 2'b01, {4'd3, 4'd3}, {2'd0, 2'd1}, 1'b0, 2'd0,
        1'b1, 2'd0, 2'd0, 1'b1);
    check_eq("t3_noway_count", 32'(resv_count_o), 2);
    // Fill on set 5 way 0 disables it; ch1 on set 6 way 3 must not.
    req(4'd5, 4'b1110, 4'b0000, 3'b101, 2'b11, {4'd6, 4'd5}, {2'd3, 2'd0}, 1'b0, 2'd0,
        1'b1, 2'd3, 2'd2, 1'b0);
    check_eq("t3_fill_count", 32'(resv_count_o), 3);

    // Table full.
    req(4'd7, 4'b0000, 4'b0000, 3'b000, 2'b00, 8'h00, 4'h0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd3, 1'b0);
    check_eq("t4_count_full", 32'(resv_count_o), 4);
    req(4'd7, 4'b0000, 4'b0000, 3'b000, 2'b00, 8'h00, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    check_eq("t4_no_accept_v_o", 32'(v_o), 0);
    check_eq("t4_count_hold", 32'(resv_count_o), 4);
    rel(2'd1);
    check_eq("t4_ready_after_release", 32'(ready_o), 1);
    check_eq("t4_count_release", 32'(resv_count_o), 3);
    req(4'd8, 4'b0000, 4'b0000, 3'b000, 2'b00, 8'h00, 4'h0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0);
    check_eq("t4_count_refill", 32'(resv_count_o), 4);

    // Release id 0 while accepting: id 0 not reusable, its way 2 still disabled.
    rel(2'd3);
    check_eq("t5_count_pre", 32'(resv_count_o), 3);
    req(4'd3, 4'b1111, 4'b0000, 3'b001, 2'b00, 8'h00, 4'h0, 1'b1, 2'd0, 1'b1, 2'd3, 2'd3, 1'b0);
    check_eq("t5_count_net", 32'(resv_count_o), 3);

    // Reset while a result is pending with 3 entries valid.
    rel(2'd1);
    hold = 1'b1;
    req(4'd9, 4'b0000, 4'b0000, 3'b000, 2'b00, 8'h00, 4'h0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0);
    check_eq("t6_count_pre", 32'(resv_count_o), 3);
    check_eq("t6_v_o_pre", 32'(v_o), 1);
    @(negedge clk_i);
    #3;
    reset_n_i = 1'b0;
    #1;
    check_eq("t6_rst_v_o", 32'(v_o), 0);
    check_eq("t6_rst_count", 32'(resv_count_o), 0);
    check_eq("t6_pending", 32'(exp_q.size()), 1);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    #1;
    hold = 1'b0;
    req(4'd10, 4'b0000, 4'b0000, 3'b000, 2'b00, 8'h00, 4'h0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0);
    check_eq("t6_post_count", 32'(resv_count_o), 1);
    // Pre-reset reservation of set 3 way 3 must be gone.
    req(4'd3, 4'b1111, 4'b0000, 3'b101, 2'b00, 8'h00, 4'h0, 1'b0, 2'd0, 1'b1, 2'd3, 2'd1, 1'b0);
    check_eq("t6_post_count2", 32'(resv_count_o), 2);

    repeat (3) @(posedge clk_i);
    #1;
    check_eq("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
